clk_run_ctrl: RTL



---
 rtl/clk_run_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/clk_run_ctrl.sv
// clk_run_ctrl: HALT / RUN / single-STEP sequencer for the slow core clock.
// Two raw active-low push-buttons are synchronised and debounced. The resulting
// press pulses drive an FSM that emits a one-cycle core clock-enable tick on clk.
// Optional build macro CLK_RUN_CTRL_BURST_EN: a step press issues BURST_LEN
// ticks spaced DIV_CNT cycles apart instead of a single tick.
module clk_run_ctrl #(
  parameter int unsigned DIV_CNT      = 500,
  parameter int unsigned DEBOUNCE_CYC = 250000,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned BURST_LEN    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_mode_n,
  input  logic             key_step_n,
  output logic             core_tick,
  output logic             running,
  output logic [CNT_W-1:0] tick_cnt
);

  localparam int unsigned DIV_W = $clog2(DIV_CNT);
  localparam int unsigned DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CNT - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

  if (DIV_CNT < 2 || DEBOUNCE_CYC < 1 || BURST_LEN < 1) begin : g_param_check
    $error("clk_run_ctrl: DIV_CNT must be >= 2, DEBOUNCE_CYC and BURST_LEN >= 1");
  end

  typedef enum logic [1:0] {
    S_HALT,
    S_RUN,
    S_STEP
`ifdef CLK_RUN_CTRL_BURST_EN
    , S_BURST
`endif
  } state_t;

  // Bit 0 carries the mode key, bit 1 the step key.
  logic [1:0]      key_raw;
  logic [1:0]      sync_a;
  logic [1:0]      sync_b;
  logic [1:0]      deb;
  logic [1:0]      deb_prev;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      press;
  logic            mode_press;
  logic            step_press;

  state_t           state;
  state_t           state_d;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_d;
  logic             div_term;

  assign key_raw = {key_step_n, key_mode_n};

  // Synchronise both keys and accept a level only after DEBOUNCE_CYC stable cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a   <= '1;
      sync_b   <= '1;
      deb      <= '1;
      deb_prev <= '1;
      for (int unsigned k = 0; k < 2; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      sync_a   <= key_raw;
      sync_b   <= sync_a;
      deb_prev <= deb;
      for (int unsigned k = 0; k < 2; k++) begin
        if (sync_b[k] != deb[k]) begin
          if (db_cnt[k] == DB_LAST) begin
            deb[k]    <= sync_b[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + DB_W'(1);
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  // Press pulse is built from registered levels only: one cycle per accepted 1->0.
  assign press      = deb_prev & ~deb;
  assign mode_press = press[0];
  assign step_press = press[1];
  assign div_term   = (div == DIV_LAST);

`ifdef CLK_RUN_CTRL_BURST_EN
  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  logic [BW-1:0] bcnt;
  logic [BW-1:0] bcnt_d;

  // Burst tick counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcnt <= '0;
    else        bcnt <= bcnt_d;
  end
`endif

  // FSM state and divider registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_HALT;
      div   <= '0;
    end else begin
      state <= state_d;
      div   <= div_d;
    end
  end

  // Next-state logic; tick and running decode from registered state/divider only.
  always_comb begin
    state_d   = state;
    div_d     = div;
    core_tick = 1'b0;
    running   = 1'b0;
`ifdef CLK_RUN_CTRL_BURST_EN
    bcnt_d    = bcnt;
`endif
    case (state)
      S_HALT: begin
        if (mode_press) begin
          state_d = S_RUN;
          div_d   = '0;
        end else if (step_press) begin
`ifdef CLK_RUN_CTRL_BURST_EN
          state_d = S_BURST;
          div_d   = '0;
          bcnt_d  = '0;
`else
          state_d = S_STEP;
`endif
        end
      end
      S_STEP: begin
        core_tick = 1'b1;
        state_d   = S_HALT;
      end
      S_RUN: begin
        running   = 1'b1;
        core_tick = div_term;
        div_d     = div_term ? '0 : div + DIV_W'(1);
        if (mode_press) state_d = S_HALT;
      end
`ifdef CLK_RUN_CTRL_BURST_EN
      S_BURST: begin
        core_tick = div_term;
        div_d     = div_term ? '0 : div + DIV_W'(1);
        if (div_term) begin
          if (bcnt == BURST_LAST) state_d = S_HALT;
          else                    bcnt_d  = bcnt + BW'(1);
        end
        if (mode_press) state_d = S_HALT;
      end
`endif
      default: state_d = S_HALT;
    endcase
  end

  // Count issued ticks, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         tick_cnt <= '0;
    else if (core_tick) tick_cnt <= tick_cnt + CNT_W'(1);
  end

endmodule
